// File: rtl/piano_pkg.sv
// Shared constants, FSM encoding and divisor table for the keyboard voice allocator.
// Z_TABLE holds 100 MHz clock-to-target divisors for the octave-1 semitones C..B.
package piano_pkg;

  localparam int NUM_KEYS   = 12;
  localparam int NUM_VOICES = 4;
  localparam int OCT_MIN    = 1;
  localparam int OCT_MAX    = 7;
  localparam int KEY_W      = 4;
  localparam int OCT_W      = 5;
  localparam int Z_W        = 32;

  typedef enum logic {
    SCAN      = 1'b0,
    STEAL_GAP = 1'b1
  } alloc_state_t;

  localparam logic [Z_W-1:0] Z_TABLE [NUM_KEYS] = '{
    32'd3057823,
    32'd2886169,
    32'd2724202,
    32'd2571289,
    32'd2427008,
    32'd2290741,
    32'd2162209,
    32'd2040858,
    32'd1926300,
    32'd1818182,
    32'd1716149,
    32'd1619827
  };

  function automatic logic [OCT_W-1:0] clamp_oct(
    input logic [OCT_W-1:0] o
  );
    if (o < OCT_W'(OCT_MIN)) return OCT_W'(OCT_MIN);
    if (o > OCT_W'(OCT_MAX)) return OCT_W'(OCT_MAX);
    return o;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Key inputs and per-voice tone-generator controls.
// master = allocator side, slave = keyboard/generator side.
interface voice_allocator_if #(
  parameter int NUM_KEYS   = piano_pkg::NUM_KEYS,
  parameter int NUM_VOICES = piano_pkg::NUM_VOICES
);
  import piano_pkg::*;

  logic [NUM_KEYS-1:0]         keys;
  logic [OCT_W-1:0]            octave_in;
  logic [NUM_VOICES-1:0]       voice_on;
  logic [NUM_VOICES*Z_W-1:0]   voice_z;
  logic [NUM_VOICES*OCT_W-1:0] voice_octave;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic                        steal_pulse;

  modport master (
    input  keys,
    input  octave_in,
    output voice_on,
    output voice_z,
    output voice_octave,
    output voice_key,
    output steal_pulse
  );

  modport slave (
    output keys,
    output octave_in,
    input  voice_on,
    input  voice_z,
    input  voice_octave,
    input  voice_key,
    input  steal_pulse
  );

endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer bringing the raw key switch levels into clk.
module key_sync #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Scans synchronized keys and maps held keys onto tone-generator voices,
// stealing the oldest voice through a one-cycle gate gap when all are busy.
module voice_allocator #(
  parameter int NUM_KEYS   = piano_pkg::NUM_KEYS,
  parameter int NUM_VOICES = piano_pkg::NUM_VOICES,
  parameter int AGE_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  voice_allocator_if.master bus
);
  import piano_pkg::*;

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef logic [VW-1:0]    vidx_t;
  typedef logic [KEY_W-1:0] kidx_t;

  logic [NUM_KEYS-1:0] keys_s;

  key_sync #(.W(NUM_KEYS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.keys),
    .q     (keys_s)
  );

  alloc_state_t state, state_d;
  kidx_t        ptr, gap_k;
  vidx_t        gap_v;
  logic         steal_q;

  logic [NUM_VOICES-1:0] on_q;
  logic [Z_W-1:0]        z_q   [NUM_VOICES];
  logic [OCT_W-1:0]      oct_q [NUM_VOICES];
  kidx_t                 key_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_q [NUM_VOICES];

  logic             held, owned, free_any;
  vidx_t            owner_v, free_v, old_v;
  logic [AGE_W-1:0] old_age;

  always_comb begin
    held     = keys_s[ptr];
    owned    = 1'b0;
    owner_v  = '0;
    free_any = 1'b0;
    free_v   = '0;
    old_v    = '0;
    old_age  = age_q[0];
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!on_q[v]) begin
        free_any = 1'b1;
        free_v   = vidx_t'(v);
      end
    end
    // strict compare keeps the lowest index on equal ages
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (on_q[v] && key_q[v] == ptr) begin
        owned   = 1'b1;
        owner_v = vidx_t'(v);
      end
      if (age_q[v] > old_age) begin
        old_age = age_q[v];
        old_v   = vidx_t'(v);
      end
    end
  end

  logic  adv, alloc, clr, steal;
  vidx_t alloc_v;
  kidx_t alloc_k;

  always_comb begin
    state_d = state;
    adv     = 1'b0;
    alloc   = 1'b0;
    alloc_v = free_v;
    alloc_k = ptr;
    clr     = 1'b0;
    steal   = 1'b0;
    unique case (state)
      SCAN: begin
        adv = 1'b1;
        if (held && !owned) begin
          if (free_any) begin
            alloc = 1'b1;
          end else begin
            steal   = 1'b1;
            state_d = STEAL_GAP;
          end
        end else if (!held && owned) begin
          clr = 1'b1;
        end
      end
      STEAL_GAP: begin
        alloc   = 1'b1;
        alloc_v = gap_v;
        alloc_k = gap_k;
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      ptr     <= '0;
      gap_k   <= '0;
      gap_v   <= '0;
      steal_q <= 1'b0;
      on_q    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        z_q[v]   <= '0;
        oct_q[v] <= '0;
        key_q[v] <= '0;
        age_q[v] <= '0;
      end
    end else begin
      state   <= state_d;
      steal_q <= steal;
      if (adv) begin
        ptr <= (ptr == kidx_t'(NUM_KEYS - 1)) ? '0 : ptr + 1'b1;
      end
      if (steal) begin
        on_q[old_v] <= 1'b0;
        gap_v       <= old_v;
        gap_k       <= ptr;
      end
      if (clr) begin
        on_q[owner_v] <= 1'b0;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (alloc && alloc_v == vidx_t'(v)) begin
          on_q[v]  <= 1'b1;
          z_q[v]   <= Z_TABLE[alloc_k];
          key_q[v] <= alloc_k;
          oct_q[v] <= clamp_oct(bus.octave_in);
          age_q[v] <= '0;
        end else if (on_q[v] && age_q[v] != '1) begin
          age_q[v] <= age_q[v] + 1'b1;
        end
      end
    end
  end

  assign bus.voice_on    = on_q;
  assign bus.steal_pulse = steal_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign bus.voice_z[v*Z_W +: Z_W]         = z_q[v];
    assign bus.voice_octave[v*OCT_W +: OCT_W] = oct_q[v];
    assign bus.voice_key[v*KEY_W +: KEY_W]   = key_q[v];
  end

endmodule
